key_schedule_ctrl: RTL and testbench
====================================

KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, number of round keys generated after the cipher key (AES-128).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port key_valid  input  1  cipher key offered on key_in.
REQ-005 SHALL have port key_ready  output  1  block can accept a new cipher key.
REQ-006 SHALL have port key_in  input  128 (block)  cipher key, word 0 in bits [127:96].
REQ-007 SHALL have port rk_idx  input  4  round-key read index, 0..NUM_ROUNDS.
REQ-008 SHALL have port rk_out  output  128 (block)  registered round-key read data.
REQ-009 SHALL have port sched_done  output  1  all NUM_ROUNDS+1 round keys are valid in the buffer.
REQ-010 SHALL have port busy  output  1  expansion in progress.

Function
REQ-011 SHALL implement FSM states IDLE, EXPAND, DONE; key_ready = 1 in IDLE and DONE, 0 in EXPAND; busy = 1 in EXPAND only; sched_done = 1 in DONE only.
REQ-012 SHALL accept a key on any edge with key_valid && key_ready: write buffer[0] = key_in, load working key = key_in, set round counter = 1, enter EXPAND.
REQ-013 SHALL, on each EXPAND edge, compute next = step(working key, round counter), write buffer[round counter] = next, load working key = next, increment the counter.
REQ-014 SHALL define step as standard AES-128 expansion: g = SubWord(RotWord(w3)) with Rcon(round) XORed into the MSB byte; w0' = w0^g, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
REQ-015 SHALL use Rcon 01,02,04,08,10,20,40,80,1B,36 for rounds 1..10.
REQ-016 SHALL leave EXPAND for DONE on the edge that writes buffer[NUM_ROUNDS]; handshake at edge T gives buffer[r] written at edge T+r and sched_done high after edge T+NUM_ROUNDS.
REQ-017 SHALL ignore key_valid during EXPAND (no stall, no restart, key not captured).
REQ-018 SHALL, on a new handshake in DONE, drop sched_done on that edge and restart expansion per REQ-012.
REQ-019 SHALL register reads: rk_out at edge N+1 = buffer[rk_idx sampled at edge N]; rk_idx > NUM_ROUNDS returns 128'h0.
REQ-020 SHALL return the pre-write contents when a read and a write address the same entry on the same edge.

Reset
REQ-021 SHALL, on rst low, asynchronously force state IDLE, round counter 0, working key 0, rk_out 0, sched_done 0, busy 0, key_ready 1.
REQ-022 SHALL treat buffer contents as invalid after reset; a reset mid-EXPAND abandons the schedule, and sched_done stays 0 until a full expansion completes.

Configuration
REQ-023 SHALL, with KEY_SCHED_ZEROIZE_EN defined, add input zeroize (1 bit): when high on an edge, every buffer entry and the working key go to 0, the FSM goes to IDLE, and zeroize takes priority over a simultaneous handshake.
REQ-024 SHALL, without KEY_SCHED_ZEROIZE_EN, have no zeroize port and keep buffer contents until they are overwritten.

Structure
REQ-025 SHALL take the block/word typedefs, the aes_sbox function, the round_const function and the NUM_ROUNDS default from the shared AES definitions package; no local S-box copy.
REQ-026 SHALL place step in a purely combinational sub-module key_round_step (inputs: block, round number; output: block), instantiated once.

Verification
REQ-027 SHALL cover the FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c -> rk_idx 1 reads a0fafe1788542cb123a339392a6c7605; rk_idx 10 reads d014f9a8c9ee2589e13f0cc8b6630ca6; sched_done rises 10 edges after the handshake.
REQ-028 SHALL cover the all-zero key -> rk_idx 1 reads 62636363 repeated four times; rk_idx 10 reads b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-029 SHALL cover key_valid held high with a different key during EXPAND -> result matches the first key only; key_ready stays 0 until DONE.
REQ-030 SHALL cover rst asserted at round 5, then a new key -> outputs at reset values immediately; the new schedule is correct, with sched_done high only after 10 further edges.
REQ-031 SHALL cover rk_idx = 11 and 15 -> rk_out = 0 one cycle later; rk_idx 0 -> cipher key.
REQ-032 SHALL cover, with KEY_SCHED_ZEROIZE_EN, zeroize pulsed in DONE together with key_valid -> all reads return 0, state IDLE, key not accepted.

Source files
------------

// File: rtl/key_schedule_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// key_schedule_ctrl_pkg : shared AES definitions (types, S-box, Rcon, FSM codes)
// Rev 1.0
//==============================================================================
package key_schedule_ctrl_pkg;

   typedef logic [127:0] block_t;
   typedef logic [31:0]  word_t;

   localparam int unsigned c_num_rounds_default = 10;

   typedef logic [1:0] state_t;
   localparam state_t c_st_idle   = 2'd0;
   localparam state_t c_st_expand = 2'd1;
   localparam state_t c_st_done   = 2'd2;

   localparam logic [7:0] c_sbox [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] aes_sbox(input logic [7:0] b);
      return c_sbox[b];
   endfunction

   function automatic logic [7:0] round_const(input logic [3:0] round);
      case (round)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/key_schedule_ctrl_if.sv
`default_nettype none
//==============================================================================
// key_schedule_ctrl_if : key load / round-key read bus. zeroize exists only
// when KEY_SCHED_ZEROIZE_EN is defined.   Rev 1.0
//==============================================================================
interface key_schedule_ctrl_if;

   logic                          key_valid;
   logic                          key_ready;
   key_schedule_ctrl_pkg::block_t key_in;
   logic [3:0]                    rk_idx;
   key_schedule_ctrl_pkg::block_t rk_out;
   logic                          sched_done;
   logic                          busy;
`ifdef KEY_SCHED_ZEROIZE_EN
   logic                          zeroize;

   modport master (output key_valid, key_in, rk_idx, zeroize,
                   input  key_ready, rk_out, sched_done, busy);
   modport slave  (input  key_valid, key_in, rk_idx, zeroize,
                   output key_ready, rk_out, sched_done, busy);
`else
   modport master (output key_valid, key_in, rk_idx,
                   input  key_ready, rk_out, sched_done, busy);
   modport slave  (input  key_valid, key_in, rk_idx,
                   output key_ready, rk_out, sched_done, busy);
`endif

endinterface
`default_nettype wire

// File: rtl/key_schedule_ctrl_key_round_step.sv
`default_nettype none
//==============================================================================
// key_round_step : one AES-128 key expansion round, purely combinational.
// Rev 1.0
//==============================================================================
module key_round_step
   import key_schedule_ctrl_pkg::*;
(
   input  block_t     i_blk,
   input  logic [3:0] i_round,
   output block_t     o_blk
);

   word_t w_w0, w_w1, w_w2, w_w3;
   word_t w_rot, w_g;
   word_t w_n0, w_n1, w_n2, w_n3;

   assign {w_w0, w_w1, w_w2, w_w3} = i_blk;
   assign w_rot = {w_w3[23:0], w_w3[31:24]};

   // Rcon lands only in the most significant byte of the substituted word
   assign w_g = {aes_sbox(w_rot[31:24]) ^ round_const(i_round),
                 aes_sbox(w_rot[23:16]),
                 aes_sbox(w_rot[15:8]),
                 aes_sbox(w_rot[7:0])};

   assign w_n0 = w_w0 ^ w_g;
   assign w_n1 = w_w1 ^ w_n0;
   assign w_n2 = w_w2 ^ w_n1;
   assign w_n3 = w_w3 ^ w_n2;

   assign o_blk = {w_n0, w_n1, w_n2, w_n3};

endmodule
`default_nettype wire

// File: rtl/key_schedule_ctrl.sv
`default_nettype none
//==============================================================================
// key_schedule_ctrl : AES-128 round-key expansion into a readable key buffer.
// Optional KEY_SCHED_ZEROIZE_EN adds a synchronous buffer wipe.   Rev 1.0
//==============================================================================
module key_schedule_ctrl
   import key_schedule_ctrl_pkg::*;
#(
   parameter int NUM_ROUNDS = c_num_rounds_default
)
(
   input  logic                clk,
   input  logic                rst,
   key_schedule_ctrl_if.slave  bus
);

   localparam logic [3:0] c_last = 4'(NUM_ROUNDS);

   state_t     r_state, w_state_nxt;
   logic [3:0] r_round;
   block_t     r_work;
   block_t     r_buf [0:NUM_ROUNDS];
   block_t     r_rk_out;
   block_t     w_next;
   logic       w_ready, w_busy, w_done;
   logic       w_zeroize, w_accept, w_expand;

`ifdef KEY_SCHED_ZEROIZE_EN
   assign w_zeroize = bus.zeroize;
`else
   assign w_zeroize = 1'b0;
`endif

   // Wipe wins over a handshake arriving on the same edge
   assign w_accept = bus.key_valid && w_ready && !w_zeroize;
   assign w_expand = (r_state == c_st_expand) && !w_zeroize;

   key_round_step u_step (
      .i_blk   (r_work),
      .i_round (r_round),
      .o_blk   (w_next)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle, c_st_done: if (w_accept) w_state_nxt = c_st_expand;
         c_st_expand:          if (r_round == c_last) w_state_nxt = c_st_done;
         default:              w_state_nxt = c_st_idle;
      endcase
      if (w_zeroize) begin
         w_state_nxt = c_st_idle;
      end
   end

   always_comb begin
      w_ready = 1'b0;
      w_busy  = 1'b0;
      w_done  = 1'b0;
      case (r_state)
         c_st_idle:   w_ready = 1'b1;
         c_st_expand: w_busy  = 1'b1;
         c_st_done: begin
            w_ready = 1'b1;
            w_done  = 1'b1;
         end
         default:     w_ready = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_round <= 4'd0;
         r_work  <= '0;
      end else if (w_zeroize) begin
         r_round <= 4'd0;
         r_work  <= '0;
      end else if (w_accept) begin
         r_round <= 4'd1;
         r_work  <= bus.key_in;
      end else if (w_expand) begin
         r_round <= r_round + 4'd1;
         r_work  <= w_next;
      end
   end

   // Buffer carries no reset: its contents are meaningless until sched_done
   always_ff @(posedge clk) begin
      if (w_zeroize) begin
         for (int i = 0; i <= NUM_ROUNDS; i++) begin
            r_buf[i] <= '0;
         end
      end else if (w_accept) begin
         r_buf[0] <= bus.key_in;
      end else if (w_expand) begin
         r_buf[r_round] <= w_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rk_out <= '0;
      end else if (bus.rk_idx > c_last) begin
         r_rk_out <= '0;
      end else begin
         r_rk_out <= r_buf[bus.rk_idx];
      end
   end

   assign bus.key_ready  = w_ready;
   assign bus.busy       = w_busy;
   assign bus.sched_done = w_done;
   assign bus.rk_out     = r_rk_out;

endmodule
`default_nettype wire

// File: tb/tb_key_schedule_ctrl.sv
`default_nettype none
//==============================================================================
// tb_key_schedule_ctrl : directed + random key loads against a FIPS-197 style
// word-expansion model with a GF(2^8)-derived S-box.   Rev 1.0
//==============================================================================
module tb_key_schedule_ctrl;
   import key_schedule_ctrl_pkg::block_t;

   localparam int NR = 10;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   key_schedule_ctrl_if bus ();

   key_schedule_ctrl #(.NUM_ROUNDS(NR)) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
   );

   int         n_checks = 0;
   int         n_err    = 0;
   logic [7:0] sb [0:255];
   block_t     exp_rk [0:NR];
   block_t     old_rk [0:NR];

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xtime(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   // S-box from multiplicative inverse + affine transform
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic expand(input block_t key);
      logic [31:0] w [0:4*NR+3];
      logic [31:0] t;
      logic [7:0]  rc;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 4*(NR+1); i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
            rc = xtime(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= NR; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [3:0] idx, input block_t exp, input string tag);
      bus.rk_idx = idx;
      tick();
      chk(tag, bus.rk_out, exp);
   endtask

   task automatic rd_all(input string tag);
      for (int r = 0; r <= NR; r++) rd(4'(r), exp_rk[r], tag);
   endtask

   task automatic wait_done(input int start, input string tag);
      int edges;
      edges = start;
      while (!bus.sched_done && edges < 40) begin
         tick();
         edges++;
      end
      chk(tag, {96'd0, 32'(edges)}, {96'd0, 32'(NR)});
   endtask

   task automatic load(input block_t k);
      bus.key_valid = 1'b1;
      bus.key_in    = k;
      tick();
      bus.key_valid = 1'b0;
      chk1("busy_in_expand", bus.busy, 1'b1);
      chk1("ready_in_expand", bus.key_ready, 1'b0);
      chk1("done_dropped", bus.sched_done, 1'b0);
      wait_done(0, "done_latency");
   endtask

   function automatic block_t rand_key();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      block_t k1, k2;
      bus.key_valid = 1'b0;
      bus.key_in    = '0;
      bus.rk_idx    = 4'd0;
`ifdef KEY_SCHED_ZEROIZE_EN
      bus.zeroize   = 1'b0;
`endif
      build_sbox();

      rst_n = 1'b0;
      #12;
      chk1("rst_ready", bus.key_ready, 1'b1);
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_done", bus.sched_done, 1'b0);
      chk("rst_rk_out", bus.rk_out, 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // FIPS-197 vector
      k1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      expand(k1);
      load(k1);
      rd(4'd1, 128'ha0fafe1788542cb123a339392a6c7605, "fips_rk1");
      rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_rk10");
      rd(4'd0, k1, "fips_rk0");
      rd_all("fips_model");

      // All-zero key
      expand('0);
      load('0);
      rd(4'd1, {4{32'h62636363}}, "zero_rk1");
      rd(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero_rk10");

      for (int n = 0; n < 3; n++) begin
         k1 = rand_key();
         expand(k1);
         load(k1);
         rd_all("rand_sched");
      end

      rd(4'd11, 128'h0, "oor_11");
      rd(4'd15, 128'h0, "oor_15");
      rd(4'd0, exp_rk[0], "idx0_key");

      // key_valid held with a different key throughout expansion
      k1 = rand_key();
      k2 = rand_key();
      expand(k1);
      bus.key_valid = 1'b1;
      bus.key_in    = k1;
      tick();
      bus.key_in    = k2;
      for (int i = 0; i < NR - 1; i++) begin
         chk1("held_ready_low", bus.key_ready, 1'b0);
         tick();
      end
      chk1("held_ready_low", bus.key_ready, 1'b0);
      bus.key_valid = 1'b0;
      tick();
      chk1("held_done", bus.sched_done, 1'b1);
      chk1("held_ready_done", bus.key_ready, 1'b1);
      rd_all("held_first_key");

      // Read and write to the same entry on one edge returns old data
      for (int r = 0; r <= NR; r++) old_rk[r] = exp_rk[r];
      k2 = rand_key();
      expand(k2);
      bus.rk_idx    = 4'd0;
      bus.key_valid = 1'b1;
      bus.key_in    = k2;
      tick();
      bus.key_valid = 1'b0;
      chk("rdw_idx0", bus.rk_out, old_rk[0]);
      bus.rk_idx = 4'd2;
      tick();
      chk("rdw_before", bus.rk_out, old_rk[2]);
      tick();
      chk("rdw_same_edge", bus.rk_out, old_rk[2]);
      tick();
      chk("rdw_after", bus.rk_out, exp_rk[2]);
      wait_done(3, "rdw_done_latency");
      rd(4'd10, exp_rk[10], "rdw_rk10");

      // Reset during round 5
      bus.key_valid = 1'b1;
      bus.key_in    = rand_key();
      tick();
      bus.key_valid = 1'b0;
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      chk1("midrst_ready", bus.key_ready, 1'b1);
      chk1("midrst_busy", bus.busy, 1'b0);
      chk1("midrst_done", bus.sched_done, 1'b0);
      chk("midrst_rk_out", bus.rk_out, 128'h0);
      #2;
      rst_n = 1'b1;
      repeat (2) tick();
      chk1("postrst_done", bus.sched_done, 1'b0);
      chk1("postrst_busy", bus.busy, 1'b0);
      k1 = rand_key();
      expand(k1);
      load(k1);
      rd_all("postrst_sched");

`ifdef KEY_SCHED_ZEROIZE_EN
      bus.zeroize   = 1'b1;
      bus.key_valid = 1'b1;
      bus.key_in    = rand_key();
      tick();
      bus.zeroize   = 1'b0;
      bus.key_valid = 1'b0;
      chk1("zero_ready", bus.key_ready, 1'b1);
      chk1("zero_busy", bus.busy, 1'b0);
      chk1("zero_done", bus.sched_done, 1'b0);
      tick();
      chk1("zero_not_accepted", bus.busy, 1'b0);
      for (int r = 0; r <= NR; r++) rd(4'(r), 128'h0, "zero_read");
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
